// File: rtl/regfile_param.sv
// Parametrised 2-read/1-write register file with byte write mask, registered
// reads with valid strobes, optional write-to-read bypass, zero register and clear sweep.
module regfile_param #(
  parameter int WIDTH    = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                 Clk,
  input  logic                 RstN,
  input  logic                 WriteEn,
  input  logic [ADDR_W-1:0]    WriteAddr,
  input  logic [WIDTH/8-1:0]   WriteMask,
  input  logic [WIDTH-1:0]     In,
  input  logic                 ReadEnA,
  input  logic [ADDR_W-1:0]    ReadAddrA,
  input  logic                 ReadEnB,
  input  logic [ADDR_W-1:0]    ReadAddrB,
  input  logic                 ClearReq,
  output logic [WIDTH-1:0]     OutA,
  output logic [WIDTH-1:0]     OutB,
  output logic                 ValidA,
  output logic                 ValidB,
  output logic                 Busy
);

  localparam int DEPTH  = 2 ** ADDR_W;
  localparam int NBYTES = WIDTH / 8;

  typedef enum logic {
    IDLE,
    CLEAR
  } stateT;

  stateT             state;
  stateT             nextState;
  logic [ADDR_W-1:0] counter;
  logic [WIDTH-1:0]  mem [DEPTH];
  logic [WIDTH-1:0]  mergedWord;
  logic [WIDTH-1:0]  readWordA;
  logic [WIDTH-1:0]  readWordB;
  logic              writeDo;

  // Writes only land in IDLE; a zero mask or a write to a hardwired entry 0 is a no-op.
  assign writeDo = (state == IDLE) && WriteEn && (WriteMask != '0) &&
                   !((ZERO_REG != 0) && (WriteAddr == '0));

  assign Busy = (state == CLEAR);

  always_comb begin
    mergedWord = mem[WriteAddr];
    for (int i = 0; i < NBYTES; i++) begin
      if (WriteMask[i]) begin
        mergedWord[8*i +: 8] = In[8*i +: 8];
      end
    end
  end

  // Read selection: zero register beats bypass, bypass beats array contents.
  always_comb begin
    readWordA = mem[ReadAddrA];
    if ((ZERO_REG != 0) && (ReadAddrA == '0)) begin
      readWordA = '0;
    end else if ((BYPASS != 0) && writeDo && (ReadAddrA == WriteAddr)) begin
      readWordA = mergedWord;
    end
  end

  always_comb begin
    readWordB = mem[ReadAddrB];
    if ((ZERO_REG != 0) && (ReadAddrB == '0)) begin
      readWordB = '0;
    end else if ((BYPASS != 0) && writeDo && (ReadAddrB == WriteAddr)) begin
      readWordB = mergedWord;
    end
  end

  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (ClearReq) nextState = CLEAR;
      CLEAR:   if (counter == '1) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // The counter wraps to 0 naturally on the final sweep edge.
  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      counter <= '0;
    end else if (state == CLEAR) begin
      counter <= counter + 1'b1;
    end else begin
      counter <= '0;
    end
  end

  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (state == CLEAR) begin
      mem[counter] <= '0;
    end else if (writeDo) begin
      mem[WriteAddr] <= mergedWord;
    end
  end

  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      OutA   <= '0;
      OutB   <= '0;
      ValidA <= 1'b0;
      ValidB <= 1'b0;
    end else begin
      ValidA <= ReadEnA;
      ValidB <= ReadEnB;
      if (ReadEnA) OutA <= readWordA;
      if (ReadEnB) OutB <= readWordB;
    end
  end

endmodule
